// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns one execute-stage memory access into a single req/ack bus
// transaction, with lane steering, load extension, alignment checks and a bus timeout.
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        we_i,
  input  logic [2:0]  mem_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, FIN} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    mem_q, mem_d;
  logic [1:0]    lane_q, lane_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  logic [3:0]    be_calc;
  logic [31:0]   wd_calc;
  logic          bad_access;
  logic [31:0]   byte_sh, half_sh, load_val;

  // Lane steering for the incoming request, and rejection of illegal/misaligned codes.
  always_comb begin
    be_calc = 4'b1111;
    wd_calc = wdata_i;
    case (mem_i[1:0])
      2'b01: begin
        be_calc = 4'b0001 << addr_i[1:0];
        wd_calc = {4{wdata_i[7:0]}};
      end
      2'b10: begin
        be_calc = 4'b0011 << {addr_i[1], 1'b0};
        wd_calc = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
    bad_access = (mem_i[2] && (mem_i[1:0] != 2'b01))
              || (we_i && (mem_i == 3'b101))
              || ((mem_i[1:0] == 2'b10) && addr_i[0])
              || ((mem_i[1:0] == 2'b11) && (addr_i[1:0] != 2'b00));
  end

  always_comb begin
    byte_sh  = bus_rdata_i >> {lane_q, 3'b000};
    half_sh  = bus_rdata_i >> {lane_q[1], 4'b0000};
    load_val = bus_rdata_i;
    case (mem_q[1:0])
      2'b01:   load_val = (mem_q == 3'b001) ? {{24{byte_sh[7]}}, byte_sh[7:0]}
                                            : {24'b0, byte_sh[7:0]};
      2'b10:   load_val = {{16{half_sh[15]}}, half_sh[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    mem_d       = mem_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          we_d   = we_i;
          mem_d  = mem_i;
          lane_d = addr_i[1:0];
          if (mem_i == 3'b000) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else if (bad_access) begin
            state_d = FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = REQ;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = we_i;
            bus_addr_d  = {addr_i[31:2], 2'b00};
            bus_be_d    = be_calc;
            bus_wdata_d = wd_calc;
          end
        end
      end
      REQ: begin
        // An ack in the final allowed cycle takes priority over the timeout.
        if (bus_ack_i) begin
          state_d   = FIN;
          bus_req_d = 1'b0;
          done_d    = 1'b1;
          if (!we_q) rdata_d = load_val;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = FIN;
          bus_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      mem_q       <= 3'b000;
      lane_q      <= 2'b00;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_be_q    <= 4'h0;
      bus_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      mem_q       <= mem_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;
  assign rdata_o     = rdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized accesses
// compared against a byte-level reference model.
module tb_lsu_mem_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  mem = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic [31:0] rdata;
  logic        done, err, busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rdata = 32'h0;

  // Observations recorded by run_access for the current transaction.
  int          obs_req_cycles, obs_done_cycle;
  logic        obs_err, obs_we, obs_stable, obs_busy_at_start;
  logic [31:0] obs_rdata, obs_addr, obs_wdata;
  logic [3:0]  obs_be;

  lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .we_i(we), .mem_i(mem),
    .addr_i(addr), .wdata_i(wdata), .bus_req_o(bus_req), .bus_we_o(bus_we),
    .bus_addr_o(bus_addr), .bus_be_o(bus_be), .bus_wdata_o(bus_wdata),
    .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata), .rdata_o(rdata),
    .done_o(done), .err_o(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: size in bytes, error rules, lane layout and extension from byte arithmetic.
  function automatic void model(input logic w, input logic [2:0] m, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output bit nobus, output bit e, output logic [3:0] be,
                                output logic [31:0] bw, output logic [31:0] ld);
    int sz, off;
    longint v;
    sz = (m == 3'd1 || m == 3'd5) ? 1 : (m == 3'd2) ? 2 : (m == 3'd3) ? 4 : 0;
    off = int'(a % 4);
    nobus = 1; e = 0; be = 4'h0; bw = 32'h0; ld = 32'h0;
    if (m == 3'd0) return;
    if (sz == 0 || (w && m == 3'd5) || (a % sz) != 0) begin e = 1; return; end
    nobus = 0;
    for (int i = 0; i < 4; i++) begin
      be[i] = (i >= off) && (i < off + sz);
      bw[8*i +: 8] = wd[8*(i % sz) +: 8];
    end
    v = longint'(rd) >> (8 * off);
    if (sz < 4) v = v & ((longint'(1) << (8 * sz)) - 1);
    if ((m == 3'd1 || m == 3'd2) && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
    ld = v[31:0];
  endfunction

  // Runs one access; ack_at = request cycle of bus_ack (0 = never). spam pulses start during REQ.
  task automatic run_access(input logic w, input logic [2:0] m, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int ack_at, input bit spam);
    @(negedge clk);
    obs_busy_at_start = busy;
    start = 1'b1; we = w; mem = m; addr = a; wdata = wd; bus_rdata = rd; bus_ack = 1'b0;
    obs_req_cycles = 0; obs_done_cycle = -1; obs_stable = 1'b1;
    obs_err = 1'bx; obs_rdata = 32'hx;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = spam && bus_req;
      if (bus_req) begin
        if (obs_req_cycles == 0) begin
          obs_be = bus_be; obs_addr = bus_addr; obs_wdata = bus_wdata; obs_we = bus_we;
        end else if (obs_be !== bus_be || obs_addr !== bus_addr ||
                     obs_wdata !== bus_wdata || obs_we !== bus_we) begin
          obs_stable = 1'b0;
        end
        obs_req_cycles++;
      end
      if (done) begin
        obs_done_cycle = c; obs_err = err; obs_rdata = rdata;
        break;
      end
      bus_ack = bus_req && (c == ack_at);
    end
    start = 1'b0; bus_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, done, err, busy} !== 104'h0) begin
      failures++;
      $display("FAIL reset_values: got req=%b we=%b addr=%h be=%b wd=%h rdata=%h done=%b err=%b busy=%b, want all 0",
               bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, done, err, busy);
    end
    reset = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_signed_byte_load();
    run_access(1'b0, 3'b001, 32'h1003, 32'h0, 32'h80FF_1234, 2, 1'b0);
    exp_rdata = 32'hFFFF_FF80;
    checks++;
    if (obs_done_cycle != 3 || obs_req_cycles != 2 || obs_err !== 1'b0) begin
      failures++;
      $display("FAIL sbyte_timing: done_cycle=%0d req=%0d err=%b, want 3 2 0", obs_done_cycle, obs_req_cycles, obs_err);
    end
    checks++;
    if (obs_be !== 4'b1000 || obs_addr !== 32'h1000 || obs_we !== 1'b0 || obs_rdata !== exp_rdata) begin
      failures++;
      $display("FAIL sbyte_data: be=%b addr=%h we=%b rdata=%h, want 1000 00001000 0 %h", obs_be, obs_addr, obs_we, obs_rdata, exp_rdata);
    end
    $display("sbyte load: rdata=%h done_cycle=%0d", obs_rdata, obs_done_cycle);
  endtask

  task automatic test_half_store();
    run_access(1'b1, 3'b010, 32'h2002, 32'hDEAD_BEEF, 32'h1111_2222, 1, 1'b0);
    checks++;
    if (obs_be !== 4'b1100 || obs_wdata !== 32'hBEEF_BEEF || obs_we !== 1'b1 || obs_addr !== 32'h2000) begin
      failures++;
      $display("FAIL hstore_bus: be=%b wd=%h we=%b addr=%h, want 1100 beefbeef 1 00002000", obs_be, obs_wdata, obs_we, obs_addr);
    end
    checks++;
    if (obs_done_cycle != 2 || obs_err !== 1'b0 || obs_rdata !== exp_rdata) begin
      failures++;
      $display("FAIL hstore_done: done_cycle=%0d err=%b rdata=%h, want 2 0 %h", obs_done_cycle, obs_err, obs_rdata, exp_rdata);
    end
    $display("half store: wd=%h done_cycle=%0d", obs_wdata, obs_done_cycle);
  endtask

  task automatic test_misaligned();
    run_access(1'b0, 3'b011, 32'h0006, 32'h0, 32'h5555_5555, 1, 1'b0);
    checks++;
    if (obs_req_cycles != 0 || obs_done_cycle != 1 || obs_err !== 1'b1 || obs_rdata !== exp_rdata) begin
      failures++;
      $display("FAIL misaligned: req=%0d done_cycle=%0d err=%b rdata=%h, want 0 1 1 %h",
               obs_req_cycles, obs_done_cycle, obs_err, obs_rdata, exp_rdata);
    end
    $display("misaligned word: err=%b done_cycle=%0d", obs_err, obs_done_cycle);
  endtask

  task automatic test_timeout();
    run_access(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
    checks++;
    if (obs_req_cycles != TO || obs_done_cycle != TO + 1 || obs_err !== 1'b1 || obs_rdata !== exp_rdata) begin
      failures++;
      $display("FAIL timeout_abort: req=%0d done_cycle=%0d err=%b rdata=%h, want %0d %0d 1 %h",
               obs_req_cycles, obs_done_cycle, obs_err, obs_rdata, TO, TO + 1, exp_rdata);
    end
    $display("timeout: req_cycles=%0d err=%b", obs_req_cycles, obs_err);
    run_access(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, TO, 1'b0);
    exp_rdata = 32'hCAFE_F00D;
    checks++;
    if (obs_req_cycles != TO || obs_done_cycle != TO + 1 || obs_err !== 1'b0 || obs_rdata !== exp_rdata) begin
      failures++;
      $display("FAIL timeout_last_ack: req=%0d done_cycle=%0d err=%b rdata=%h, want %0d %0d 0 %h",
               obs_req_cycles, obs_done_cycle, obs_err, obs_rdata, TO, TO + 1, exp_rdata);
    end
    $display("ack in last cycle: err=%b rdata=%h", obs_err, obs_rdata);
  endtask

  task automatic test_unsigned_and_illegal();
    run_access(1'b0, 3'b101, 32'h0000_0001, 32'h0, 32'h0000_9A00, 1, 1'b0);
    exp_rdata = 32'h0000_009A;
    checks++;
    if (obs_rdata !== exp_rdata || obs_err !== 1'b0 || obs_be !== 4'b0010) begin
      failures++;
      $display("FAIL ubyte_load: rdata=%h err=%b be=%b, want %h 0 0010", obs_rdata, obs_err, obs_be, exp_rdata);
    end
    $display("ubyte load: rdata=%h", obs_rdata);
    run_access(1'b0, 3'b110, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, 1, 1'b0);
    checks++;
    if (obs_req_cycles != 0 || obs_done_cycle != 1 || obs_err !== 1'b1 || obs_rdata !== exp_rdata) begin
      failures++;
      $display("FAIL illegal_110: req=%0d done_cycle=%0d err=%b rdata=%h, want 0 1 1 %h",
               obs_req_cycles, obs_done_cycle, obs_err, obs_rdata, exp_rdata);
    end
    run_access(1'b1, 3'b101, 32'h0000_0000, 32'h1234_5678, 32'h0, 1, 1'b0);
    checks++;
    if (obs_req_cycles != 0 || obs_done_cycle != 1 || obs_err !== 1'b1) begin
      failures++;
      $display("FAIL store_ubyte: req=%0d done_cycle=%0d err=%b, want 0 1 1", obs_req_cycles, obs_done_cycle, obs_err);
    end
    run_access(1'b0, 3'b000, 32'h0000_0003, 32'h0, 32'h0, 1, 1'b0);
    checks++;
    if (obs_req_cycles != 0 || obs_done_cycle != 1 || obs_err !== 1'b0 || obs_rdata !== exp_rdata) begin
      failures++;
      $display("FAIL none_access: req=%0d done_cycle=%0d err=%b rdata=%h, want 0 1 0 %h",
               obs_req_cycles, obs_done_cycle, obs_err, obs_rdata, exp_rdata);
    end
    $display("illegal/none codes: last err=%b", obs_err);
  endtask

  task automatic test_reset_mid();
    int extra_done;
    @(negedge clk);
    start = 1'b1; we = 1'b0; mem = 3'b011; addr = 32'h40; bus_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_req !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_req: bus_req=%b, want 1", bus_req);
    end
    reset = 1'b1;
    #1;
    exp_rdata = 32'h0;
    checks++;
    if (bus_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rdata !== exp_rdata) begin
      failures++;
      $display("FAIL reset_mid_drop: req=%b busy=%b done=%b rdata=%h, want 0 0 0 0", bus_req, busy, done, rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    checks++;
    if (extra_done != 0) begin
      failures++;
      $display("FAIL reset_mid_nodone: done pulses=%0d, want 0", extra_done);
    end
    $display("reset mid-transaction: bus_req dropped, no done");
  endtask

  task automatic test_start_while_busy();
    int extra_done;
    run_access(1'b0, 3'b010, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 3, 1'b1);
    exp_rdata = 32'hFFFF_8001;
    checks++;
    if (obs_done_cycle != 4 || obs_err !== 1'b0 || obs_rdata !== exp_rdata) begin
      failures++;
      $display("FAIL busy_start_txn: done_cycle=%0d err=%b rdata=%h, want 4 0 %h", obs_done_cycle, obs_err, obs_rdata, exp_rdata);
    end
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || bus_req) extra_done++;
    end
    checks++;
    if (extra_done != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_start_ignored: extra activity=%0d busy=%b, want 0 0", extra_done, busy);
    end
    $display("start while busy: one done, rdata=%h", obs_rdata);
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 3'b011, 32'h0000_0010, 32'hA5A5_0F0F, 32'h0, 1, 1'b0);
    run_access(1'b0, 3'b001, 32'h0000_0011, 32'h0, 32'h0000_7F00, 1, 1'b0);
    exp_rdata = 32'h0000_007F;
    checks++;
    if (obs_busy_at_start !== 1'b0 || obs_done_cycle != 2 || obs_rdata !== exp_rdata) begin
      failures++;
      $display("FAIL back_to_back: busy_at_start=%b done_cycle=%0d rdata=%h, want 0 2 %h",
               obs_busy_at_start, obs_done_cycle, obs_rdata, exp_rdata);
    end
    $display("back to back: rdata=%h", obs_rdata);
  endtask

  task automatic test_random();
    bit nobus, e_exp;
    logic [3:0] be_exp;
    logic [31:0] bw_exp, ld_exp, a, wd, rd;
    logic w;
    logic [2:0] m;
    int ack_at, exp_req, exp_done;
    bit exp_e;
    for (int n = 0; n < 60; n++) begin
      w = 1'($urandom_range(0, 1));
      m = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = (m == 3'd3) ? 2'b00 : (m == 3'd2) ? {a[1], 1'b0} : a[1:0];
      wd = $urandom; rd = $urandom;
      ack_at = $urandom_range(1, TO + 1);
      if (ack_at > TO) ack_at = 0;
      model(w, m, a, wd, rd, nobus, e_exp, be_exp, bw_exp, ld_exp);
      run_access(w, m, a, wd, rd, ack_at, 1'b0);
      if (nobus) begin
        exp_req = 0; exp_done = 1; exp_e = e_exp;
      end else if (ack_at == 0) begin
        exp_req = TO; exp_done = TO + 1; exp_e = 1;
      end else begin
        exp_req = ack_at; exp_done = ack_at + 1; exp_e = 0;
        if (!w) exp_rdata = ld_exp;
      end
      checks++;
      if (obs_req_cycles != exp_req || obs_done_cycle != exp_done || obs_err !== exp_e || obs_rdata !== exp_rdata) begin
        failures++;
        $display("FAIL rand_result[%0d]: we=%b mem=%b addr=%h req=%0d done=%0d err=%b rdata=%h, want %0d %0d %b %h",
                 n, w, m, a, obs_req_cycles, obs_done_cycle, obs_err, obs_rdata, exp_req, exp_done, exp_e, exp_rdata);
      end
      if (!nobus) begin
        checks++;
        if (obs_be !== be_exp || obs_wdata !== bw_exp || obs_we !== w ||
            obs_addr !== {a[31:2], 2'b00} || obs_stable !== 1'b1) begin
          failures++;
          $display("FAIL rand_bus[%0d]: be=%b wd=%h we=%b addr=%h stable=%b, want %b %h %b %h 1",
                   n, obs_be, obs_wdata, obs_we, obs_addr, obs_stable, be_exp, bw_exp, w, {a[31:2], 2'b00});
        end
      end
      $display("rand %0d: we=%b mem=%b addr=%h ack_at=%0d err=%b rdata=%h", n, w, m, a, ack_at, obs_err, obs_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_signed_byte_load();
    test_half_store();
    test_misaligned();
    test_timeout();
    test_unsigned_and_illegal();
    test_back_to_back();
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
